// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and
// FIFO sizing helpers used by the buffered transmitter (and the receiver).
package uart_tx_buffered_pkg;

    // Frame FSM states; encodings are fixed so the receiver can share them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 100 MHz sysclk / 9600 baud, rounded; both UART directions use this.
    localparam int DEFAULT_CLKS_PER_BIT = 10417;
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int DEFAULT_CNT_W        = 16;
    localparam int DATA_BITS            = 8;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// CPU-side bus of the buffered UART transmitter: write strobe, enable,
// serial line and the status flags polled by the peripheral register.
interface uart_tx_buffered_if
    import uart_tx_buffered_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);
    logic [7:0]                          writedata;
    logic                                send_trigger;
    logic                                send_enable;
    logic                                UART_TX;
    logic                                send_work_state;
    logic                                send_finish;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [count_width(FIFO_DEPTH)-1:0]  fifo_count;
    logic                                overflow;

    // Peripheral/CPU side: writes bytes, reads status.
    modport master (
        output writedata, send_trigger, send_enable,
        input  UART_TX, send_work_state, send_finish,
        input  fifo_full, fifo_empty, fifo_count, overflow
    );

    // Transmitter side.
    modport slave (
        input  writedata, send_trigger, send_enable,
        output UART_TX, send_work_state, send_finish,
        output fifo_full, fifo_empty, fifo_count, overflow
    );

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Byte-wide synchronous FIFO. The head entry is readable combinationally so
// the consumer can load it in the same cycle it pops. Callers guard push
// against full and pop against empty; the FIFO itself does not.
module uart_sync_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic                          pop,
    input  logic [7:0]                    wdata,
    output logic [7:0]                    rdata,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = count_width(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage array has no reset; stale entries are never read because
    // the occupancy count gates every pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == COUNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes written on the rising edge of
// send_trigger are queued in a FIFO and drained onto UART_TX one frame per
// byte (start, 8 data bits LSB first, stop). All outputs are registered and
// follow the FSM state by one cycle.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic               sysclk,
    input  logic               reset,
    uart_tx_buffered_if.slave  bus
);
    localparam int             COUNT_W   = count_width(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

    logic               trig_d;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               bit_done;
    logic [7:0]         head;
    logic               full;
    logic               empty;
    logic [COUNT_W-1:0] count;
    logic               overflow_q;

    tx_state_t          state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               tx_q;
    logic               work_q;
    logic               finish_q;

    assign push_req = bus.send_trigger & ~trig_d;
    assign push     = push_req & ~full;
    assign bit_done = (baud_cnt == LAST_TICK);
    assign pop      = bus.send_enable & ~empty &
                      ((state == IDLE) | ((state == STOP) & bit_done));

    // Trigger history; cleared on reset so a trigger held through reset
    // is seen as a fresh edge.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= bus.send_trigger;
        end
    end

    // Sticky record of any write dropped because the FIFO was full.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push_req && full) begin
            overflow_q <= 1'b1;
        end
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.writedata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Frame FSM: sequences start/data/stop bits and registers line and status outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
            work_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q   <= 1'b1;
                    work_q <= 1'b0;
                    if (pop) begin
                        shift    <= head;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx_q   <= 1'b0;
                    work_q <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx_q   <= shift[0];
                    work_q <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx_q   <= 1'b1;
                    work_q <= 1'b1;
                    if (bit_done) begin
                        finish_q <= 1'b1;
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.UART_TX         = tx_q;
    assign bus.send_work_state = work_q;
    assign bus.send_finish     = finish_q;
    assign bus.fifo_full       = full;
    assign bus.fifo_empty      = empty;
    assign bus.fifo_count      = count;
    assign bus.overflow        = overflow_q;

endmodule
